// File: rtl/sgdmac_wr_sched.sv
// Write-command scheduler: round-robin arbitration of N_CH channels onto one
// write engine, with length sanity check, completion pulses and a watchdog.
module sgdmac_wr_sched #(
  parameter int N_CH   = 4,
  parameter int WDOG_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid_i,
  input  logic [48*N_CH-1:0]   req_cmd_i,
  output logic [N_CH-1:0]      req_ready_o,
  input  logic [N_CH-1:0]      ch_en_i,
  output logic                 eng_start_o,
  output logic [47:0]          eng_cmd_o,
  input  logic                 eng_done_i,
  output logic [N_CH-1:0]      cpl_valid_o,
  output logic                 cpl_err_o,
  output logic [2:0]           grant_id_o,
  output logic                 busy_o,
  output logic                 wdog_o,
  input  logic                 wdog_clr_i
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WACK, S_WDONE, S_CPL} state_t;

  state_t            state, state_nx;
  logic [2:0]        ptr, owner;
  logic [47:0]       cmd_q;
  logic              err_q;
  logic [WDOG_W-1:0] wcnt, wcnt_nx;
  logic              wdog_q, wdog_set, waiting;

  logic [N_CH-1:0]   elig, rot;
  logic [3:0]        shamt, off, sum;
  logic              found, accept, win_bad;
  logic [2:0]        win;
  logic [47:0]       win_cmd;

  assign elig = req_valid_i & ch_en_i;

  // Rotate so bit 0 is the channel just after the pointer; lowest set bit wins.
  always_comb begin
    shamt = 4'(ptr) + 4'd1;
    rot   = N_CH'({elig, elig} >> shamt);
    found = 1'b0;
    off   = 4'd0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 4'(i);
      end
    end
    sum = shamt + off;
    if (sum >= 4'(N_CH)) sum = sum - 4'(N_CH);
    win = 3'(sum);
    win_cmd = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (win == 3'(k)) win_cmd = req_cmd_i[48*k +: 48];
    end
    win_bad = (win_cmd[15:0] == 16'd0) || (win_cmd[1:0] != 2'd0);
  end

  assign accept = (state == S_IDLE) && found && eng_done_i;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      req_ready_o[k] = accept && !rst && (win == 3'(k));
      cpl_valid_o[k] = (state == S_CPL) && (owner == 3'(k));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = win_bad ? S_CPL : S_ISSUE;
      S_ISSUE: state_nx = S_WACK;
      S_WACK:  if (!eng_done_i) state_nx = S_WDONE;
      S_WDONE: if (eng_done_i) state_nx = S_CPL;
      S_CPL:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign waiting  = (state == S_WACK) || (state == S_WDONE);
  assign wcnt_nx  = (&wcnt) ? wcnt : wcnt + WDOG_W'(1);
  assign wdog_set = waiting && (&wcnt_nx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= 3'(N_CH-1);
      owner  <= 3'd0;
      cmd_q  <= 48'd0;
      err_q  <= 1'b0;
      wcnt   <= '0;
      wdog_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= win;
        cmd_q <= win_cmd;
        err_q <= win_bad;
      end
      if (state == S_CPL) ptr <= owner;
      if (state == S_ISSUE) wcnt <= '0;
      else if (waiting)     wcnt <= wcnt_nx;
      // A pending expiry outranks a same-cycle clear.
      if (wdog_set)        wdog_q <= 1'b1;
      else if (wdog_clr_i) wdog_q <= 1'b0;
    end
  end

  assign eng_start_o = (state == S_ISSUE);
  assign eng_cmd_o   = cmd_q;
  assign cpl_err_o   = (state == S_CPL) && err_q;
  assign grant_id_o  = owner;
  assign busy_o      = (state != S_IDLE);
  assign wdog_o      = wdog_q;

endmodule

// File: doc/sgdmac_wr_sched.md
SGDMAC_WR_SCHED -- requirements
Module: sgdmac_wr_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter WDOG_W, default 16, watchdog counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  N_CH  per-channel write-command valid.
REQ-006 SHALL have port req_cmd_i  input  48*N_CH  per-channel command; channel k at [48k+47:48k], format {dst address[31:0], length bytes[15:0]}.
REQ-007 SHALL have port req_ready_o  output  N_CH  per-channel accept; at most one bit high per cycle.
REQ-008 SHALL have port ch_en_i  input  N_CH  per-channel enable mask.
REQ-009 SHALL have port eng_start_o  output  1  start pulse to write engine.
REQ-010 SHALL have port eng_cmd_o  output  48  command to write engine, same format as req_cmd_i.
REQ-011 SHALL have port eng_done_i  input  1  engine idle level (high = idle).
REQ-012 SHALL have port cpl_valid_o  output  N_CH  one-cycle completion pulse per channel.
REQ-013 SHALL have port cpl_err_o  output  1  qualifies cpl_valid_o; 1 = command rejected.
REQ-014 SHALL have port grant_id_o  output  3  index of current/last owner channel.
REQ-015 SHALL have port busy_o  output  1  high in any state except S_IDLE.
REQ-016 SHALL have port wdog_o  output  1  sticky watchdog-expired flag.
REQ-017 SHALL have port wdog_clr_i  input  1  synchronous clear of wdog_o.

Function
REQ-018 SHALL implement FSM states S_IDLE, S_ISSUE, S_WACK, S_WDONE, S_CPL.
REQ-019 S_IDLE: eligible = req_valid_i & ch_en_i; if eligible!=0 and eng_done_i=1, SHALL assert req_ready_o for the round-robin winner in the same cycle (combinational), latch its command and index.
REQ-020 Round-robin SHALL search from pointer+1 upward, wrapping at N_CH-1 to 0; pointer updates to the owner index in S_CPL only.
REQ-021 Latched command with length==0 or length[1:0]!=0 SHALL go S_IDLE->S_CPL with error=1, no engine start; otherwise S_IDLE->S_ISSUE.
REQ-022 S_ISSUE: eng_start_o=1 exactly one cycle, eng_cmd_o=latched command; next state S_WACK.
REQ-023 S_WACK: stay until eng_done_i=0, then S_WDONE.
REQ-024 S_WDONE: stay until eng_done_i=1, then S_CPL.
REQ-025 S_CPL: cpl_valid_o[owner]=1 and cpl_err_o=error for one cycle; pointer<=owner; next S_IDLE.
REQ-026 eng_cmd_o SHALL hold the latched command in all states; eng_start_o SHALL be 0 outside S_ISSUE.
REQ-027 Best-case latency: accept cycle T, eng_start_o at T+1, cpl pulse one cycle after eng_done_i returns high; back-to-back accept no earlier than cycle after S_CPL.
REQ-028 ch_en_i deassert for owner mid-command SHALL NOT abort; command completes normally.
REQ-029 Watchdog counter SHALL clear on S_ISSUE, increment each cycle in S_WACK/S_WDONE, saturate at all-ones; reaching all-ones SHALL set wdog_o; FSM continues waiting.
REQ-030 wdog_clr_i SHALL clear wdog_o; set and clear in same cycle -> set wins.
REQ-031 No request accepted while eng_done_i=0 in S_IDLE.

Reset
REQ-032 rst SHALL asynchronously force S_IDLE, pointer=N_CH-1 (channel 0 first), latched command=0, grant_id_o=0, error=0, watchdog=0, wdog_o=0.
REQ-033 During reset all outputs SHALL be 0 (req_ready_o, eng_start_o, eng_cmd_o, cpl_valid_o, cpl_err_o, busy_o, wdog_o).
REQ-034 Reset mid-command SHALL drop the in-flight command without cpl pulse.

Verification
REQ-035 Ch0 cmd {0x1000_0000,0x0100}, engine model drops done 1 cycle after start, idle 20 cycles later -> one start with that cmd, cpl_valid_o[0] pulse, cpl_err_o=0.
REQ-036 All 4 channels valid continuously, legal cmds -> grant order 0,1,2,3,0, one start per command.
REQ-037 Ch2 length 0x0000 and ch1 length 0x0006 -> no eng_start_o, cpl_err_o=1 pulses on respective channels.
REQ-038 WDOG_W=4, engine never returns done -> wdog_o set after 15 cycles in S_WACK/S_WDONE; wdog_clr_i clears it.
REQ-039 ch_en_i=4'b1010 with all valid -> only channels 1 and 3 granted, alternating.
REQ-040 rst asserted in S_WDONE -> all outputs 0 immediately; after release channel 0 wins first.
